double_frame_buffer: RTL and testbench

- Two-bank, 1 bit/pixel frame store sitting directly downstream of frame_renderer.
- Takes the renderer's wr_en/wr_addr/wr_data into the back bank and serves the display scan-out from the front bank.
- Generates the swap pulse that frame_renderer consumes. The swap happens on a display frame boundary, once every FRAME_DIVIDER frames, which sets the game tick rate.

---
 rtl/double_frame_buffer_pkg.sv | 8 +
 rtl/fb_bank_ram.sv | 25 ++
 rtl/double_frame_buffer.sv | 123 ++++++++++++
 tb/tb_double_frame_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/double_frame_buffer_pkg.sv
// Shared types and constants for the two-bank 1 bit/pixel frame store.
package double_frame_buffer_pkg;

  typedef logic pixel_t;

  localparam logic FRONT_RESET_BANK = 1'b0;

endpackage

// File: rtl/fb_bank_ram.sv
// One frame bank: simple dual-port RAM, single write port and single registered read port.
module fb_bank_ram
  import double_frame_buffer_pkg::*;
#(
  parameter int DEPTH      = 307200,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  pixel_t                wr_data,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output pixel_t                rd_data
);

  pixel_t mem [DEPTH];

  // No reset on the array or read register so the bank maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/double_frame_buffer.sv
// Two-bank frame store: renderer writes the back bank, scan-out reads the front bank,
// and the banks swap on every FRAME_DIVIDER-th frame_start.
//
// state          | meaning
// COUNT(k, sel)  | k frame_starts seen since the last swap, bank sel is front
// k == DIV-1     | next counted frame_start toggles sel, clears k and pulses swap
module double_frame_buffer
  import double_frame_buffer_pkg::*;
#(
  parameter  int HOR_ACTIVE_PIXELS = 640,
  parameter  int VER_ACTIVE_PIXELS = 480,
  parameter  int FRAME_DIVIDER     = 2,
  localparam int ADDR_WIDTH        = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS),
  localparam int DIV_WIDTH         = $clog2(FRAME_DIVIDER+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  frame_start,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  pixel_t                wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output pixel_t                rd_data,
  output logic                  rd_valid,
  output logic                  swap,
  output logic                  front_sel
);

  localparam int                  DEPTH     = HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(FRAME_DIVIDER-1);

  logic [DIV_WIDTH-1:0] frame_cnt, frame_cnt_nxt;
  logic                 front_sel_nxt;
  logic                 swap_nxt;

  logic   wr_in_range, rd_in_range;
  logic   wr_fire, rd_fire;
  logic   we0, we1, re0, re1;
  pixel_t q0, q1;
  logic   rd_sel;
  logic   rd_zero;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;

  // Writes are also gated by rst so nothing lands in a bank while reset is held.
  assign wr_fire = rst & ce & wr_en & wr_in_range;
  assign rd_fire = ce & rd_en;

  // Bank choice uses front_sel from before the edge on which it may toggle.
  assign we0 = wr_fire & front_sel;
  assign we1 = wr_fire & ~front_sel;
  assign re0 = rd_fire & rd_in_range & ~front_sel;
  assign re1 = rd_fire & rd_in_range & front_sel;

  always_comb begin
    frame_cnt_nxt = frame_cnt;
    front_sel_nxt = front_sel;
    swap_nxt      = 1'b0;
    if (ce && frame_start) begin
      if (frame_cnt == DIV_LAST) begin
        frame_cnt_nxt = '0;
        front_sel_nxt = ~front_sel;
        swap_nxt      = 1'b1;
      end else begin
        frame_cnt_nxt = frame_cnt + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      front_sel <= FRONT_RESET_BANK;
      swap      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_sel    <= FRONT_RESET_BANK;
      rd_zero   <= 1'b1;
    end else begin
      frame_cnt <= frame_cnt_nxt;
      front_sel <= front_sel_nxt;
      swap      <= swap_nxt;
      rd_valid  <= rd_fire;
      if (rd_fire) begin
        rd_sel  <= front_sel;
        rd_zero <= ~rd_in_range;
      end
    end
  end

  // rd_zero starts set so rd_data reads 0 out of reset and for out-of-range reads.
  assign rd_data = rd_zero ? 1'b0 : (rd_sel ? q1 : q0);

  fb_bank_ram #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank0 (
    .clk     (clk),
    .we      (we0),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .re      (re0),
    .rd_addr (rd_addr),
    .rd_data (q0)
  );

  fb_bank_ram #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank1 (
    .clk     (clk),
    .we      (we1),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .re      (re1),
    .rd_addr (rd_addr),
    .rd_data (q1)
  );

endmodule

// File: tb/tb_double_frame_buffer.sv
// Bench for double_frame_buffer: two instances (divider 2 and 1) share stimulus and are
// checked each cycle against a frame-count based reference model.
module tb_double_frame_buffer;

  localparam int H  = 10;
  localparam int V  = 6;
  localparam int D  = H*V;
  localparam int AW = $clog2(D);
  localparam int DIVS [2] = '{2, 1};

  logic          clk = 1'b0;
  logic          rst;
  logic          ce, frame_start, wr_en, wr_data, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [1:0]    rd_data_v, rd_valid_v, swap_v, front_v;

  int errors = 0;
  int checks = 0;

  bit mem_m [2][2][D];
  int frames [2];
  bit e_valid [2];
  bit e_data [2];
  bit e_swap [2];

  always #5 clk = ~clk;

  double_frame_buffer #(
    .HOR_ACTIVE_PIXELS (H),
    .VER_ACTIVE_PIXELS (V),
    .FRAME_DIVIDER     (2)
  ) dut_div2 (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data_v[0]),
    .rd_valid    (rd_valid_v[0]),
    .swap        (swap_v[0]),
    .front_sel   (front_v[0])
  );

  double_frame_buffer #(
    .HOR_ACTIVE_PIXELS (H),
    .VER_ACTIVE_PIXELS (V),
    .FRAME_DIVIDER     (1)
  ) dut_div1 (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data_v[1]),
    .rd_valid    (rd_valid_v[1]),
    .swap        (swap_v[1]),
    .front_sel   (front_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Front bank follows from how many frame_starts were counted: one swap per DIV of them.
  function automatic int front_m(input int d);
    return (frames[d] / DIVS[d]) % 2;
  endfunction

  task automatic check_all(input string ctx);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s front_sel[div%0d]", ctx, DIVS[d]), 32'(front_v[d]),    32'(front_m(d)));
      chk($sformatf("%s swap[div%0d]", ctx, DIVS[d]),      32'(swap_v[d]),     32'(e_swap[d]));
      chk($sformatf("%s rd_valid[div%0d]", ctx, DIVS[d]),  32'(rd_valid_v[d]), 32'(e_valid[d]));
      chk($sformatf("%s rd_data[div%0d]", ctx, DIVS[d]),   32'(rd_data_v[d]),  32'(e_data[d]));
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int f;
      f = front_m(d);
      if (ce && wr_en && int'(wr_addr) < D) mem_m[d][1-f][int'(wr_addr)] = wr_data;
      if (ce && rd_en) begin
        e_valid[d] = 1'b1;
        e_data[d]  = (int'(rd_addr) < D) ? mem_m[d][f][int'(rd_addr)] : 1'b0;
      end else begin
        e_valid[d] = 1'b0;
      end
      e_swap[d] = 1'b0;
      if (ce && frame_start) begin
        frames[d]++;
        e_swap[d] = (frames[d] % DIVS[d]) == 0;
      end
    end
  endtask

  task automatic step(input string ctx, input bit c, input bit fs, input bit we, input int wa,
                      input bit wd, input bit re, input int ra);
    @(negedge clk);
    ce          = c;
    frame_start = fs;
    wr_en       = we;
    wr_addr     = AW'(wa);
    wr_data     = wd;
    rd_en       = re;
    rd_addr     = AW'(ra);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  // Assert reset off-edge, check its async effect, and hold it across an edge with a write pending.
  task automatic do_reset(input string ctx);
    @(negedge clk);
    rst         = 1'b0;
    ce          = 1'b1;
    frame_start = 1'b1;
    wr_en       = 1'b1;
    wr_addr     = AW'($urandom_range(0, D-1));
    wr_data     = 1'b1;
    rd_en       = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      frames[d]  = 0;
      e_valid[d] = 1'b0;
      e_data[d]  = 1'b0;
      e_swap[d]  = 1'b0;
    end
    check_all(ctx);
    @(posedge clk);
    #1;
    check_all({ctx, " held"});
    @(negedge clk);
    frame_start = 1'b0;
    wr_en       = 1'b0;
    rst         = 1'b1;
  endtask

  task automatic clear_back();
    for (int a = 0; a < D; a++) begin
      @(negedge clk);
      ce = 1'b1; frame_start = 1'b0; wr_en = 1'b1; wr_addr = AW'(a); wr_data = 1'b0; rd_en = 1'b0;
      @(posedge clk);
      model_edge();
    end
  endtask

  task automatic pulse_fs_unchecked();
    @(negedge clk);
    ce = 1'b1; frame_start = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; frame_start = 1'b0; wr_en = 1'b0; wr_data = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0;
    for (int d = 0; d < 2; d++) begin
      frames[d] = 0; e_valid[d] = 1'b0; e_data[d] = 1'b0; e_swap[d] = 1'b0;
    end

    do_reset("reset");
    idle("post-reset idle");

    // Put every bank of both instances into a known all-zero state.
    clear_back();
    pulse_fs_unchecked();
    clear_back();
    pulse_fs_unchecked();
    clear_back();

    // Reset mid-count: two counted frames are needed again before the divider-2 swap.
    do_reset("reset2");
    step("fs1", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    idle("fs1 idle");
    do_reset("reset mid-count");
    step("after-rst fs1", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    idle("after-rst idle1");
    step("after-rst fs2", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    idle("after-rst swap");
    idle("after-rst swap gone");

    // Write to back bank, invisible until the swap.
    do_reset("reset3");
    step("wr addr5", 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b0, 0);
    step("rd addr5 pre", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 5);
    idle("rd addr5 pre valid drop");
    step("fs a", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    idle("fs a idle");
    step("fs b", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    idle("swap idle");
    step("rd addr5 post", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 5);
    idle("rd addr5 post idle");

    // Back-to-back frame_starts, every one counted.
    for (int i = 0; i < 4; i++) step($sformatf("b2b fs%0d", i), 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    idle("b2b idle");

    // Write and read coincident with the toggling frame_start.
    do_reset("reset4");
    step("coinc fs1", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    step("coinc wr10", 1'b1, 1'b1, 1'b1, 10, 1'b1, 1'b1, 10);
    step("coinc rd10", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 10);
    idle("coinc idle");

    // Clock enable low: everything ignored.
    step("ce0", 1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b1, 3);
    step("ce0 again", 1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b1, 4);
    idle("ce0 idle");

    // Out-of-range write and read.
    do_reset("reset5");
    step("wr addr0", 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0);
    step("wr addr oor", 1'b1, 1'b0, 1'b1, D, 1'b0, 1'b0, 0);
    step("rd addr oor", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, D);
    step("rd addr oor+3", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, D+3);
    step("oor fs1", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    step("oor fs2", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
    step("rd addr0", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 0);
    idle("oor idle");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand reset");
      end else begin
        step("rand",
             $urandom_range(0, 7) != 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1,
             int'($urandom_range(0, D+3)),
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1,
             int'($urandom_range(0, D+3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
